ram_bist_ctrl: RTL

RAM_BIST_CTRL -- requirements
Module: ram_bist_ctrl

---
 rtl/ram_pkg.sv | 25 ++
 rtl/ram_addr_counter.sv | 43 ++++
 rtl/ram_bist_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// ram_pkg : shared FSM encoding, default widths and BIST pattern function
// Revision 1.0
// ============================================================================
package ram_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_WRITE = 3'd1;
    localparam state_t ST_READ  = 3'd2;
    localparam state_t ST_CHECK = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    // Pattern for address n; callers keep the low DATA_W bits (mod 2^DATA_W).
    function automatic logic [31:0] ram_pattern(input logic [31:0] n, input logic [31:0] seed);
        return (n << 1) + seed;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_addr_counter.sv
`default_nettype none
// ============================================================================
// ram_addr_counter : wrapping address counter with clear, enable, terminal count
// Revision 1.0
// ============================================================================
module ram_addr_counter #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = (count_q == {W{1'b1}});

endmodule
`default_nettype wire

// File: rtl/ram_bist_ctrl.sv
`default_nettype none
// ============================================================================
// ram_bist_ctrl : fill-then-check BIST sequencer for a single-port RAM
// Revision 1.0
// ============================================================================
module ram_bist_ctrl
    import ram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] seed,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_in,
    output logic              write,
    output logic              select,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   fail_count,
    output logic [ADDR_W-1:0] first_fail_addr
);

    localparam logic [ADDR_W:0] FAIL_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   seed_q, seed_d;
    logic [ADDR_W:0]     fail_count_q, fail_count_d;
    logic [ADDR_W-1:0]   first_fail_addr_q, first_fail_addr_d;
    logic                pass_q, pass_d;
    logic                rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;

    logic [ADDR_W-1:0]   cnt;
    logic                cnt_clr;
    logic                cnt_en;
    logic                cnt_tc;

    logic [31:0]         wr_pat_full;
    logic [31:0]         exp_pat_full;
    logic [DATA_W-1:0]   wr_pat;
    logic [DATA_W-1:0]   exp_pat;
    logic                unused_pat_hi;
    logic                in_write;
    logic                in_read;
    logic                in_run;
    logic                mismatch;

    ram_addr_counter #(
        .W (ADDR_W)
    ) u_addr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (cnt),
        .tc    (cnt_tc)
    );

    assign wr_pat_full   = ram_pattern(32'(cnt), 32'(seed_q));
    assign exp_pat_full  = ram_pattern(32'(rd_addr_q), 32'(seed_q));
    assign wr_pat        = wr_pat_full[DATA_W-1:0];
    assign exp_pat       = exp_pat_full[DATA_W-1:0];
    assign unused_pat_hi = ^{wr_pat_full[31:DATA_W], exp_pat_full[31:DATA_W]};

    assign in_write = (state_q == ST_WRITE);
    assign in_read  = (state_q == ST_READ);
    assign in_run   = in_write || in_read || (state_q == ST_CHECK);

    // Read data returns one cycle after its address, so compare against the delayed address.
    assign mismatch = rd_valid_q && (mem_rdata != exp_pat);

    always_comb begin
        state_d           = state_q;
        seed_d            = seed_q;
        fail_count_d      = fail_count_q;
        first_fail_addr_d = first_fail_addr_q;
        pass_d            = pass_q;
        rd_valid_d        = 1'b0;
        rd_addr_d         = rd_addr_q;
        cnt_clr           = 1'b0;
        cnt_en            = 1'b0;

        if (mismatch) begin
            fail_count_d = fail_count_q + FAIL_ONE;
            if (fail_count_q == '0) begin
                first_fail_addr_d = rd_addr_q;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d           = ST_WRITE;
                    seed_d            = seed;
                    fail_count_d      = '0;
                    first_fail_addr_d = '0;
                    pass_d            = 1'b0;
                    cnt_clr           = 1'b1;
                end
            end
            ST_WRITE: begin
                cnt_en = 1'b1;
                if (cnt_tc) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                cnt_en     = 1'b1;
                rd_valid_d = 1'b1;
                rd_addr_d  = cnt;
                if (cnt_tc) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_d = ST_DONE;
                pass_d  = (fail_count_d == '0);
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort && in_run) begin
            state_d    = ST_IDLE;
            cnt_clr    = 1'b1;
            cnt_en     = 1'b0;
            rd_valid_d = 1'b0;
            pass_d     = pass_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= ST_IDLE;
            seed_q            <= '0;
            fail_count_q      <= '0;
            first_fail_addr_q <= '0;
            pass_q            <= 1'b0;
            rd_valid_q        <= 1'b0;
            rd_addr_q         <= '0;
        end else begin
            state_q           <= state_d;
            seed_q            <= seed_d;
            fail_count_q      <= fail_count_d;
            first_fail_addr_q <= first_fail_addr_d;
            pass_q            <= pass_d;
            rd_valid_q        <= rd_valid_d;
            rd_addr_q         <= rd_addr_d;
        end
    end

    assign write           = in_write;
    assign select          = in_write || in_read;
    assign address         = (in_write || in_read) ? cnt : '0;
    assign data_in         = in_write ? wr_pat : '0;
    assign busy            = in_run;
    assign done            = (state_q == ST_DONE);
    assign pass            = pass_q;
    assign fail_count      = fail_count_q;
    assign first_fail_addr = first_fail_addr_q;

endmodule
`default_nettype wire
